// File: rtl/tt_cam_buffer_ctrl.sv
// tt_cam_buffer_ctrl
//   Allocation/retirement controller for a CAM buffer instance. Entries are
//   allocated in ring order at the tail, filled later by ID, and retired in
//   order from the head once their data is valid. Supports drain and flush.
//
// Ports:
//   i_clk / i_reset_n              clock, async active-low reset
//   i_alloc_* / o_alloc_*          allocation handshake, tag in, ID out (tail)
//   i_fill_* / o_fill_err          data fill by ID, error pulse on illegal fill
//   o_retire_* / i_retire_ready    in-order retire of the head entry
//   i_drain_req / o_drain_done     block alloc until empty, pulse when done
//   i_flush                        discard all entries (one FLUSH cycle)
//   o_count                        occupied entries
//   o_write_tag_* / o_write_data_* CAM write ports
//   o_set/clear_*_valid            CAM valid-bit controls (one bit per entry)
//   i_broadside_*                  CAM broadside valid/value readback
//   o_perf_max_count               high-watermark of o_count
//
// Optional feature macro: TT_CAM_BUFFER_CTRL_PERF_EN (adds o_perf_max_count).
module tt_cam_buffer_ctrl #(
  parameter int TAG_WIDTH    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ENTRIES      = 8,
  parameter int ENTRIES_LOG2 = $clog2(ENTRIES)
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_alloc_valid,
  output logic                                 o_alloc_ready,
  input  logic [TAG_WIDTH-1:0]                 i_alloc_tag,
  output logic [ENTRIES_LOG2-1:0]              o_alloc_id,
  input  logic                                 i_fill_en,
  input  logic [ENTRIES_LOG2-1:0]              i_fill_id,
  input  logic [DATA_WIDTH-1:0]                i_fill_data,
  output logic                                 o_fill_err,
  output logic                                 o_retire_valid,
  input  logic                                 i_retire_ready,
  output logic [ENTRIES_LOG2-1:0]              o_retire_id,
  output logic [TAG_WIDTH-1:0]                 o_retire_tag,
  output logic [DATA_WIDTH-1:0]                o_retire_data,
  input  logic                                 i_drain_req,
  output logic                                 o_drain_done,
  input  logic                                 i_flush,
  output logic [ENTRIES_LOG2:0]                o_count,
  output logic                                 o_write_tag_en,
  output logic [ENTRIES_LOG2-1:0]              o_write_tag_addr,
  output logic [TAG_WIDTH-1:0]                 o_write_tag_value,
  output logic                                 o_write_data_en,
  output logic [ENTRIES_LOG2-1:0]              o_write_data_addr,
  output logic [DATA_WIDTH-1:0]                o_write_data_value,
  output logic [ENTRIES-1:0]                   o_set_tag_valid,
  output logic [ENTRIES-1:0]                   o_clear_tag_valid,
  output logic [ENTRIES-1:0]                   o_set_data_valid,
  output logic [ENTRIES-1:0]                   o_clear_data_valid,
  input  logic [ENTRIES-1:0]                   i_broadside_tag_valid,
  input  logic [ENTRIES-1:0]                   i_broadside_data_valid,
  input  logic [ENTRIES-1:0][TAG_WIDTH-1:0]    i_broadside_tag_value,
  input  logic [ENTRIES-1:0][DATA_WIDTH-1:0]   i_broadside_data_value
`ifdef TT_CAM_BUFFER_CTRL_PERF_EN
  ,
  output logic [ENTRIES_LOG2:0]                o_perf_max_count
`endif
);

  localparam int CW = ENTRIES_LOG2 + 1;

  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [ENTRIES_LOG2-1:0] head, tail;
  logic [CW-1:0]           count, count_nxt;
  logic                    alloc_fire, retire_fire, fill_ok, fill_act;
  logic [ENTRIES-1:0]      head_oh, tail_oh, fill_oh;

  assign head_oh = ENTRIES'(1) << head;
  assign tail_oh = ENTRIES'(1) << tail;
  assign fill_oh = ENTRIES'(1) << i_fill_id;

  // Alloc: no bypass from a same-cycle retire, so a full buffer stalls
  // one cycle even while its head is retiring.
  assign o_alloc_ready     = (state == RUN) && (count != CW'(ENTRIES)) && !i_flush;
  assign alloc_fire        = i_alloc_valid && o_alloc_ready;
  assign o_alloc_id        = tail;
  assign o_write_tag_en    = alloc_fire;
  assign o_write_tag_addr  = tail;
  assign o_write_tag_value = i_alloc_tag;

  // Fill: legal only for an allocated entry whose data is not yet valid.
  assign fill_act           = i_fill_en && (state != FLUSH);
  assign fill_ok            = i_broadside_tag_valid[i_fill_id] && !i_broadside_data_valid[i_fill_id];
  assign o_write_data_en    = fill_act && fill_ok;
  assign o_fill_err         = fill_act && !fill_ok;
  assign o_write_data_addr  = i_fill_id;
  assign o_write_data_value = i_fill_data;

  // Retire from head once its data is valid.
  assign o_retire_valid = (state != FLUSH) && (count != '0) && i_broadside_data_valid[head] && !i_flush;
  assign retire_fire    = o_retire_valid && i_retire_ready;
  assign o_retire_id    = head;
  assign o_retire_tag   = i_broadside_tag_value[head];
  assign o_retire_data  = i_broadside_data_value[head];

  // Valid controls; alloc and retire/fill always hit distinct entries so ORing is safe.
  assign o_set_tag_valid    = alloc_fire ? tail_oh : '0;
  assign o_set_data_valid   = o_write_data_en ? fill_oh : '0;
  assign o_clear_tag_valid  = (state == FLUSH) ? '1 : (retire_fire ? head_oh : '0);
  assign o_clear_data_valid = (state == FLUSH) ? '1 :
                              ((retire_fire ? head_oh : '0) | (alloc_fire ? tail_oh : '0));

  assign o_count = count;

  always_comb begin
    count_nxt = count;
    if (state == FLUSH) begin
      count_nxt = '0;
    end else begin
      case ({alloc_fire, retire_fire})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    o_drain_done = 1'b0;
    case (state)
      RUN:   if (i_drain_req) state_nxt = DRAIN;
      DRAIN: if (count == '0) begin
               o_drain_done = 1'b1;
               state_nxt    = RUN;
             end
      FLUSH: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    // Flush dominates everything, including a drain about to complete.
    if (i_flush) begin
      state_nxt    = FLUSH;
      o_drain_done = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == FLUSH) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (alloc_fire)  tail <= tail + 1'b1;
        if (retire_fire) head <= head + 1'b1;
      end
    end
  end

`ifdef TT_CAM_BUFFER_CTRL_PERF_EN
  // High-watermark survives flush; only reset clears it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                   o_perf_max_count <= '0;
    else if (count_nxt > o_perf_max_count) o_perf_max_count <= count_nxt;
  end
`endif

endmodule
